// File: rtl/imu_frame_assembler_pkg.sv
// Shared types and constants for the IMU frame assembler: FSM state
// encoding, frame geometry, and word-slot indices within a frame.
package imu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KICK    = 2'd1,
        COLLECT = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam int FRAME_BYTES = 14;
    localparam int FRAME_WORDS = 7;
    localparam int BYTE_IDX_W  = $clog2(FRAME_BYTES);

    // Word slots in stream order; word k is built from bytes 2k (MSB) and 2k+1.
    localparam int ACCEL_X = 0;
    localparam int ACCEL_Y = 1;
    localparam int ACCEL_Z = 2;
    localparam int TEMP    = 3;
    localparam int GYRO_X  = 4;
    localparam int GYRO_Y  = 5;
    localparam int GYRO_Z  = 6;

    // Big-endian pairing of two stream bytes into one frame word.
    function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imu_frame_assembler_sample_tick_gen.sv
// Free-running divider: counts 0..PERIOD-1 from reset and flags the last
// count so the frame request rate is one tick every PERIOD cycles.
module sample_tick_gen #(
    parameter int unsigned PERIOD = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Advance the divider, wrapping on the last count.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imu_frame_assembler.sv
// IMU frame assembler: kicks an I2C burst read every sample tick, gathers the
// 14 returned bytes in a shadow buffer and publishes all seven words at once.
// Optional build macro FRAME_TIMEOUT_EN adds a kick-to-last-byte watchdog
// (TIMEOUT_CYCLES) that drops a stalled frame and pulses frame_err.
module imu_frame_assembler
    import imu_pkg::*;
#(
    parameter int unsigned CLK_MAIN       = 50_000_000,
    parameter int unsigned SAMPLE_HZ      = 500
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               en_start,
    output logic               read_now,
    input  logic [7:0]         data,
    input  logic               data_avalid,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [7:0]         overrun_cnt
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);

    state_t                  state_q, next_state;
    logic                    tick;
    logic [BYTE_IDX_W-1:0]   byte_cnt_q;
    logic [7:0]              shadow_q [FRAME_BYTES];
    logic [15:0]             words_q  [FRAME_WORDS];
    logic                    byte_take;
    logic                    byte_last;
    logic                    timeout_hit;

    // Every transaction on this bus is a read.
    assign read_now = 1'b1;

    sample_tick_gen #(
        .PERIOD (CLK_MAIN / SAMPLE_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign byte_take = (state_q == COLLECT) && data_avalid;
    assign byte_last = byte_take && (byte_cnt_q == LAST_BYTE);

    // Next-state logic; a completed frame wins over a coincident timeout.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (tick) next_state = KICK;
            KICK:    next_state = COLLECT;
            COLLECT: begin
                if (byte_last)        next_state = PUBLISH;
                else if (timeout_hit) next_state = IDLE;
            end
            PUBLISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus registered control outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_start    <= 1'b0;
            frame_valid <= 1'b0;
            byte_cnt_q  <= '0;
            overrun_cnt <= '0;
        end else begin
            state_q     <= next_state;
            en_start    <= (next_state == KICK);
            frame_valid <= (state_q == PUBLISH);
            if (state_q == KICK) begin
                byte_cnt_q <= '0;
            end else if (byte_take) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (tick && (state_q != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    // Capture incoming bytes into the shadow buffer while collecting.
    // NOTE: the shadow buffer has no reset; every entry is rewritten before PUBLISH reads it.
    always_ff @(posedge clk) begin
        if (byte_take) begin
            shadow_q[byte_cnt_q] <= data;
        end
    end

    // Publish the whole shadow buffer at once so consumers never see a mixed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FRAME_WORDS; k++) words_q[k] <= '0;
        end else if (state_q == PUBLISH) begin
            for (int k = 0; k < FRAME_WORDS; k++) begin
                words_q[k] <= pack_word(shadow_q[2*k], shadow_q[2*k+1]);
            end
        end
    end

    assign accel_x = words_q[ACCEL_X];
    assign accel_y = words_q[ACCEL_Y];
    assign accel_z = words_q[ACCEL_Z];
    assign temp    = words_q[TEMP];
    assign gyro_x  = words_q[GYRO_X];
    assign gyro_y  = words_q[GYRO_Y];
    assign gyro_z  = words_q[GYRO_Z];

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] timer_q;

    // Timer reads 1 in the first COLLECT cycle, so it equals cycles since the kick.
    assign timeout_hit = (state_q == COLLECT) && (timer_q == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog from kick to last byte; flags a dropped frame for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state_q == KICK) begin
                timer_q <= 32'd1;
            end else if (state_q == COLLECT) begin
                timer_q <= timer_q + 32'd1;
            end
            frame_err <= timeout_hit && !byte_last;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Directed bench for imu_frame_assembler with a 100-cycle sample period.
// Also covers the watchdog path when built with FRAME_TIMEOUT_EN (limit 50).
module tb_imu_frame_assembler;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_start;
    logic               read_now;
    logic [7:0]         data;
    logic               data_avalid;
    logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic               frame_valid;
    logic               frame_err;
    logic [7:0]         overrun_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    imu_frame_assembler #(
        .CLK_MAIN       (100),
        .SAMPLE_HZ      (1)
`ifdef FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_start    (en_start),
        .read_now    (read_now),
        .data        (data),
        .data_avalid (data_avalid),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .temp        (temp),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, leaving the bench 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        data        = b;
        data_avalid = 1'b1;
        step(1);
        data_avalid = 1'b0;
        data        = 8'h00;
    endtask

    task automatic send_run(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) send(first + 8'(i));
    endtask

    // Wait for the next en_start pulse within a cycle budget.
    task automatic wait_kick(input int budget, output int waited, output int at_cyc);
        logic found;
        found  = 1'b0;
        waited = 0;
        at_cyc = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            waited++;
            if (en_start) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        check("kick_found", 16'(found), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int waited, kick_cyc, hits, err_cyc;

        rst_n       = 1'b0;
        data        = 8'h00;
        data_avalid = 1'b0;
        step(3);

        // Reset values.
        check("rst_en_start", 16'(en_start), 16'd0);
        check("rst_read_now", 16'(read_now), 16'd1);
        check("rst_accel_x", accel_x, 16'h0000);
        check("rst_gyro_z", gyro_z, 16'h0000);
        check("rst_frame_valid", 16'(frame_valid), 16'd0);
        check("rst_frame_err", 16'(frame_err), 16'd0);
        check("rst_overrun", 16'(overrun_cnt), 16'd0);

        rst_n = 1'b1;

        // First kick lands 100 edges after release and is one cycle wide.
        wait_kick(200, waited, kick_cyc);
        check("first_kick_cycle", 16'(waited), 16'd100);
        step(1);
        check("kick_width", 16'(en_start), 16'd0);

        // Frame 0x01..0x0E.
        send_run(8'h01, 14);
        check("f1_valid_early", 16'(frame_valid), 16'd0);
        check("f1_hold_early", accel_x, 16'h0000);
        step(1);
        check("f1_valid", 16'(frame_valid), 16'd1);
        check("f1_accel_x", accel_x, 16'h0102);
        check("f1_accel_z", accel_z, 16'h0506);
        check("f1_temp", temp, 16'h0708);
        check("f1_gyro_x", gyro_x, 16'h090A);
        check("f1_gyro_z", gyro_z, 16'h0D0E);
        step(1);
        check("f1_valid_single", 16'(frame_valid), 16'd0);

        // Frame with 0x80 in byte 0; old words held until PUBLISH.
        wait_kick(200, waited, kick_cyc);
        check("f2_kick_period", 16'(waited), 16'd83);
        step(1);
        send(8'h80);
        send(8'h00);
        send_run(8'h31, 12);
        check("f2_hold_accel_x", accel_x, 16'h0102);
        check("f2_hold_gyro_z", gyro_z, 16'h0D0E);
        step(1);
        check("f2_valid", 16'(frame_valid), 16'd1);
        check("f2_accel_x", accel_x, 16'h8000);
        check("f2_accel_x_neg", 16'(accel_x < 0), 16'd1);
        check("f2_accel_y", accel_y, 16'h3132);
        check("f2_gyro_z", gyro_z, 16'h3B3C);

        // Stall after 5 bytes across 3 ticks.
        wait_kick(200, waited, kick_cyc);
        step(1);
        send_run(8'h10, 5);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (en_start) hits++;
        end
        check("stall_no_kick", 16'(hits), 16'd0);
        check("stall_overrun", 16'(overrun_cnt), 16'd3);
        check("stall_hold", accel_x, 16'h8000);
        send_run(8'h15, 9);
        step(1);
        check("stall_valid", 16'(frame_valid), 16'd1);
        check("stall_accel_x", accel_x, 16'h1011);
        check("stall_temp", temp, 16'h1617);
        check("stall_gyro_z", gyro_z, 16'h1C1D);
        check("stall_overrun_kept", 16'(overrun_cnt), 16'd3);

        // Frame stopped after 6 bytes.
        wait_kick(200, waited, kick_cyc);
        step(1);
        send_run(8'h20, 6);
`ifdef FRAME_TIMEOUT_EN
        err_cyc = 0;
        for (int i = 0; i < 100 && err_cyc == 0; i++) begin
            step(1);
            if (frame_err) err_cyc = cyc;
        end
        check("to_err_delay", 16'(err_cyc - kick_cyc), 16'd50);
        step(1);
        check("to_err_width", 16'(frame_err), 16'd0);
        check("to_valid_none", 16'(frame_valid), 16'd0);
        check("to_words_held", accel_x, 16'h1011);
        check("to_gyro_held", gyro_z, 16'h1C1D);
        wait_kick(200, waited, err_cyc);
        check("to_rekick_period", 16'(err_cyc - kick_cyc), 16'd100);
        step(1);
        send_run(8'h60, 9);
`else
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (frame_err) hits++;
        end
        check("noto_err_tied", 16'(hits), 16'd0);
        check("noto_words_held", accel_x, 16'h1011);
        send_run(8'h26, 3);
`endif

        // Reset mid-frame after 9 bytes.
        rst_n = 1'b0;
        #1;
        check("mid_rst_accel_x", accel_x, 16'h0000);
        check("mid_rst_overrun", 16'(overrun_cnt), 16'd0);
        check("mid_rst_en_start", 16'(en_start), 16'd0);
        step(2);
        rst_n = 1'b1;

        // Strobes while IDLE are ignored; the kick timing restarts from zero.
        send_run(8'h55, 3);
        wait_kick(200, waited, kick_cyc);
        check("post_rst_kick", 16'(waited), 16'd97);
        step(1);
        send_run(8'hA0, 14);
        step(1);
        check("post_rst_valid", 16'(frame_valid), 16'd1);
        check("post_rst_accel_x", accel_x, 16'hA0A1);
        check("post_rst_accel_y", accel_y, 16'hA2A3);
        check("post_rst_temp", temp, 16'hA6A7);
        check("post_rst_gyro_y", gyro_y, 16'hAAAB);
        check("post_rst_gyro_z", gyro_z, 16'hACAD);
        check("post_rst_overrun", 16'(overrun_cnt), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imu_frame_assembler.md
# imu_frame_assembler

Sequences periodic burst reads from the IMU over the I2C master and assembles the returned byte stream into one coherent 7-word sensor frame (accel XYZ, temperature, gyro XYZ). It sits directly around the I2C master: it drives the master's `en_start`/`read_now` trigger upstream and consumes its `data`/`data_avalid` byte stream downstream. It publishes frames atomically to the attitude-estimation logic.

## Interface
- `CLK_MAIN`, 50000000, system clock frequency in Hz.
- `SAMPLE_HZ`, 500, frame request rate in Hz; tick period is `CLK_MAIN/SAMPLE_HZ` cycles.
- `TIMEOUT_CYCLES`, 200000, watchdog limit from kick to last byte. Used only with `FRAME_TIMEOUT_EN`.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en_start`  output  1  one-cycle pulse that starts an I2C transaction.
- `read_now`  output  1  tied high after reset; every transaction is a read.
- `data`  input  8  received byte from the I2C master.
- `data_avalid`  input  1  one-cycle strobe; `data` is valid in the same cycle.
- `accel_x`, `accel_y`, `accel_z`, `temp`, `gyro_x`, `gyro_y`, `gyro_z`  output  16 each  signed frame words.
- `frame_valid`  output  1  one-cycle pulse when all seven words have updated.
- `frame_err`  output  1  one-cycle pulse when a frame is dropped by timeout.
- `overrun_cnt`  output  8  saturating count of sample ticks that arrived while busy.

## Operation
- Sample tick: a free-running counter from 0 to `CLK_MAIN/SAMPLE_HZ-1` produces a 1-cycle tick on wrap. It runs from reset.
- States and transitions:
  - IDLE: on tick, go to KICK.
  - KICK: assert `en_start` for exactly 1 cycle, clear `byte_cnt`, go to COLLECT.
  - COLLECT: on each `data_avalid`, write `data` into a shadow byte buffer at index `byte_cnt`, then increment. When the 14th byte (index 13) is captured, go to PUBLISH.
  - PUBLISH: copy the shadow buffer to the output words in one cycle, pulse `frame_valid`, return to IDLE.
- Word packing: the stream is big-endian, MSB first. Word k is `{byte[2k], byte[2k+1]}`. Order of k: accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z.
- `data_avalid` outside COLLECT is ignored. Bytes beyond index 13 cannot occur, because the state has already left COLLECT.
- A tick in any state other than IDLE increments `overrun_cnt`, saturating at 255. No kick is issued for it and it is not queued.
- A tick and a `data_avalid` in the same cycle are both processed.
- Output words change only in PUBLISH. Consumers never see a mixed frame.
- Reset mid-frame: all state clears asynchronously, the partial frame is discarded, and the next tick restarts cleanly.

## Timing
- Reset values:
  - `en_start` = 0, `read_now` = 1.
  - All words = 0.
  - `frame_valid` = 0, `frame_err` = 0, `overrun_cnt` = 0.
  - State = IDLE, tick counter = 0.
- All outputs are registered.
- `en_start` rises 1 cycle after the tick, then stays low until the next kick. This satisfies the master's rule that `en_start` is low between operations.
- `frame_valid` and the new words appear 2 cycles after the cycle in which the 14th `data_avalid` is sampled.
- Minimum spacing between kicks is one tick period.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - A cycle counter starts at KICK and runs through COLLECT.
  - On reaching `TIMEOUT_CYCLES` without the 14th byte, the block pulses `frame_err` for 1 cycle, discards the shadow buffer, and returns to IDLE. Output words are unchanged.
- `FRAME_TIMEOUT_EN` undefined:
  - No counter exists and `frame_err` is tied 0.
  - COLLECT waits indefinitely.

## Structure
- Package `imu_pkg` holds:
  - the state enum (IDLE, KICK, COLLECT, PUBLISH);
  - `FRAME_BYTES` = 14 and `FRAME_WORDS` = 7;
  - word-index constants (ACCEL_X = 0 … GYRO_Z = 6).
- One sub-module, `sample_tick_gen`: the parameterised divider producing the 1-cycle tick.

## Test plan
- Reset release → all outputs at their reset values. With `SAMPLE_HZ` scaled to a 100-cycle period, the first `en_start` pulse occurs at cycle 100 and is exactly 1 cycle wide.
- Kick, then feed bytes 0x01..0x0E → `accel_x` = 0x0102, `temp` = 0x0708, `gyro_z` = 0x0D0E, with a single `frame_valid` pulse 2 cycles after the last strobe.
- Feed bytes with 0x80 in byte 0 → `accel_x` = 0x8000, which is negative as a signed value. Previous words are held until PUBLISH.
- Stall COLLECT at byte 5 across 3 ticks → `overrun_cnt` = 3 and no extra `en_start`. Completing the frame then publishes normally.
- With `FRAME_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, stop after 6 bytes → `frame_err` pulses at kick+50, the words are unchanged, and the next tick kicks again.
- Assert `rst_n` low after 9 bytes, then release and feed a full frame 0xA0..0xAD → `accel_x` = 0xA0A1, with no residue from the aborted frame. Strobes sent while in IDLE are ignored.
